// File: rtl/accum_bank.sv
// accum_bank: CHANNELS independent signed accumulators with add/sub/load/clear,
// saturating or wrapping overflow, and one registered result beat per operation.
module accum_bank #(
    parameter int WIDTH = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 1,
    localparam int CW = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_chan,
    input  logic [1:0]          in_op,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_chan,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_ovf,
    output logic [CHANNELS-1:0] ovf_sticky
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc_q [CHANNELS];
    logic [WIDTH-1:0] acc_d [CHANNELS];
    logic [CHANNELS-1:0] sticky_q, sticky_d;
    logic out_valid_q, out_valid_d;
    logic [CW-1:0] out_chan_q, out_chan_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic out_ovf_q, out_ovf_d;

    logic accept;
    logic in_range;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH:0] sum;
    logic ovf;
    logic op_ovf;

    assign in_ready = !out_valid_q || out_ready;
    assign accept = in_valid && in_ready;
    assign in_range = 32'(in_chan) < CHANNELS;

    // Operand read and arithmetic on the addressed channel only.
    always_comb begin
        cur = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_chan == CW'(i)) cur = acc_q[i];
        end
        if (in_op == OP_SUB) sum = {cur[WIDTH-1], cur} - {in_data[WIDTH-1], in_data};
        else sum = {cur[WIDTH-1], cur} + {in_data[WIDTH-1], in_data};
        ovf = sum[WIDTH] != sum[WIDTH-1];
        new_val = '0;
        op_ovf = 1'b0;
        unique case (in_op)
            OP_ADD, OP_SUB: begin
                op_ovf = ovf;
                if (ovf && SATURATE != 0) new_val = sum[WIDTH] ? MIN_V : MAX_V;
                else new_val = sum[WIDTH-1:0];
            end
            OP_LOAD: new_val = in_data;
            default: new_val = '0;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        sticky_d = sticky_q;
        out_valid_d = out_valid_q;
        out_chan_d = out_chan_q;
        out_data_d = out_data_q;
        out_ovf_d = out_ovf_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_chan_d = in_chan;
            out_data_d = '0;
            out_ovf_d = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_range && in_chan == CW'(i)) begin
                    acc_d[i] = new_val;
                    // add/sub keep the flag; load/clear (op[1]=1) drop it
                    sticky_d[i] = op_ovf || (sticky_q[i] && !in_op[1]);
                end
            end
            if (in_range) begin
                out_data_d = new_val;
                out_ovf_d = op_ovf;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
            sticky_q <= '0;
            out_valid_q <= 1'b0;
            out_chan_q <= '0;
            out_data_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sticky_q <= sticky_d;
            out_valid_q <= out_valid_d;
            out_chan_q <= out_chan_d;
            out_data_q <= out_data_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan = out_chan_q;
    assign out_data = out_data_q;
    assign out_ovf = out_ovf_q;
    assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: three configurations share one stimulus stream
// (32b saturating, 8b saturating, 8b wrapping with 3 channels).
module tb_accum_bank;
    typedef struct {
        bit rst;
        bit valid;
        logic [1:0] chan;
        logic [1:0] op;
        logic [31:0] data;
        bit ordy;
        bit chk;
        longint ea;
        longint eb;
        longint ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [1:0] in_chan = '0;
    logic [1:0] in_op = '0;
    logic [31:0] in_data = '0;
    logic out_ready = 1'b1;

    logic rdy_a, vld_a, ovf_a;
    logic [1:0] chan_a;
    logic [31:0] data_a;
    logic [3:0] stk_a;
    logic rdy_b, vld_b, ovf_b;
    logic [1:0] chan_b;
    logic [7:0] data_b;
    logic [3:0] stk_b;
    logic rdy_c, vld_c, ovf_c;
    logic [1:0] chan_c;
    logic [7:0] data_c;
    logic [2:0] stk_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accum_bank #(.WIDTH(32), .CHANNELS(4), .SATURATE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .in_chan(in_chan), .in_op(in_op), .in_data(in_data),
        .out_valid(vld_a), .out_ready(out_ready), .out_chan(chan_a),
        .out_data(data_a), .out_ovf(ovf_a), .ovf_sticky(stk_a));

    accum_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .in_chan(in_chan), .in_op(in_op), .in_data(in_data[7:0]),
        .out_valid(vld_b), .out_ready(out_ready), .out_chan(chan_b),
        .out_data(data_b), .out_ovf(ovf_b), .ovf_sticky(stk_b));

    accum_bank #(.WIDTH(8), .CHANNELS(3), .SATURATE(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
        .in_chan(in_chan), .in_op(in_op), .in_data(in_data[7:0]),
        .out_valid(vld_c), .out_ready(out_ready), .out_chan(chan_c),
        .out_data(data_c), .out_ovf(ovf_c), .ovf_sticky(stk_c));

    // Reference model: plain integer arithmetic per configuration.
    int wid [3] = '{32, 8, 8};
    int sat [3] = '{1, 1, 0};
    int nch [3] = '{4, 4, 3};
    longint acc [3][4];
    bit stk [3][4];
    bit ev = 0;
    longint echan = 0;
    longint edata [3];
    bit eovf [3];

    function automatic longint sx(longint v, int w);
        longint r;
        r = v & ((64'sd1 <<< w) - 1);
        if (r >= (64'sd1 <<< (w - 1))) r = r - (64'sd1 <<< w);
        return r;
    endfunction

    task automatic model_step(input vec_t v, input bit rdy);
        longint a, x, full, lo, hi;
        int ch;
        if (v.rst) begin
            ev = 0;
            echan = 0;
            for (int d = 0; d < 3; d++) begin
                edata[d] = 0;
                eovf[d] = 0;
                for (int i = 0; i < 4; i++) begin
                    acc[d][i] = 0;
                    stk[d][i] = 0;
                end
            end
        end else if (v.valid && rdy) begin
            ev = 1;
            echan = longint'(v.chan);
            ch = int'(v.chan);
            for (int d = 0; d < 3; d++) begin
                edata[d] = 0;
                eovf[d] = 0;
                if (ch < nch[d]) begin
                    a = acc[d][ch];
                    x = sx(longint'(v.data), wid[d]);
                    lo = -(64'sd1 <<< (wid[d] - 1));
                    hi = (64'sd1 <<< (wid[d] - 1)) - 1;
                    if (v.op == 2'd2) begin
                        acc[d][ch] = x;
                        stk[d][ch] = 0;
                    end else if (v.op == 2'd3) begin
                        acc[d][ch] = 0;
                        stk[d][ch] = 0;
                    end else begin
                        full = (v.op == 2'd0) ? a + x : a - x;
                        if (full > hi || full < lo) begin
                            eovf[d] = 1;
                            stk[d][ch] = 1;
                            if (sat[d] != 0) full = (full > hi) ? hi : lo;
                            else full = sx(full, wid[d]);
                        end
                        acc[d][ch] = full;
                    end
                    edata[d] = acc[d][ch];
                end
            end
        end else if (v.ordy) begin
            ev = 0;
        end
    endtask

    function automatic longint stk_word(int d);
        longint r = 0;
        for (int i = 0; i < 4; i++) if (stk[d][i]) r = r | (64'sd1 <<< i);
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        bit exp_rdy;
        rst = v.rst;
        in_valid = v.valid;
        in_chan = v.chan;
        in_op = v.op;
        in_data = v.data;
        out_ready = v.ordy;
        #1;
        exp_rdy = !ev || v.ordy;
        if (!v.rst) begin
            chk("in_ready_a", longint'(rdy_a), longint'(exp_rdy));
            chk("in_ready_b", longint'(rdy_b), longint'(exp_rdy));
            chk("in_ready_c", longint'(rdy_c), longint'(exp_rdy));
        end
        model_step(v, exp_rdy);
        @(posedge clk);
        #1;
        chk("valid_a", longint'(vld_a), longint'(ev));
        chk("valid_b", longint'(vld_b), longint'(ev));
        chk("valid_c", longint'(vld_c), longint'(ev));
        if (ev || v.rst) begin
            chk("chan_a", longint'(chan_a), echan);
            chk("chan_b", longint'(chan_b), echan);
            chk("chan_c", longint'(chan_c), echan);
            chk("data_a", longint'($signed(data_a)), edata[0]);
            chk("data_b", longint'($signed(data_b)), edata[1]);
            chk("data_c", longint'($signed(data_c)), edata[2]);
            chk("ovf_a", longint'(ovf_a), longint'(eovf[0]));
            chk("ovf_b", longint'(ovf_b), longint'(eovf[1]));
            chk("ovf_c", longint'(ovf_c), longint'(eovf[2]));
        end
        chk("sticky_a", longint'(stk_a), stk_word(0));
        chk("sticky_b", longint'(stk_b), stk_word(1));
        chk("sticky_c", longint'(stk_c), stk_word(2) & 7);
        if (v.chk) begin
            chk("tbl_data_a", longint'($signed(data_a)), v.ea);
            chk("tbl_data_b", longint'($signed(data_b)), v.eb);
            chk("tbl_data_c", longint'($signed(data_c)), v.ec);
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(bit r, bit vl, int ch, int op, longint d, bit ordy,
                                bit c = 0, longint ea = 0, longint eb = 0, longint ec = 0);
        vec_t v;
        v.rst = r;
        v.valid = vl;
        v.chan = 2'(ch);
        v.op = 2'(op);
        v.data = d[31:0];
        v.ordy = ordy;
        v.chk = c;
        v.ea = ea;
        v.eb = eb;
        v.ec = ec;
        return v;
    endfunction

    function automatic vec_t rnd();
        longint d;
        d = longint'($urandom);
        if ($urandom_range(0, 2) == 0) d = longint'($urandom_range(0, 16)) - 8;
        return mk(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), d, $urandom_range(0, 3) != 0);
    endfunction

    vec_t tbl [$];

    initial begin
        // ops: 0 add, 1 sub, 2 load, 3 clear
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 5, 1, 1, 5, 5, 5));
        tbl.push_back(mk(0, 1, 1, 0, 7, 1, 1, 12, 12, 12));
        tbl.push_back(mk(0, 1, 1, 0, -3, 1, 1, 9, 9, 9));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 100, 1, 1, 100, 100, 100));
        tbl.push_back(mk(0, 1, 0, 0, 50, 1, 1, 150, 127, -106));
        tbl.push_back(mk(0, 1, 0, 1, 50, 1, 1, 100, 77, 100));
        tbl.push_back(mk(0, 1, 0, 3, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 2, -128, 1, 1, -128, -128, -128));
        tbl.push_back(mk(0, 1, 2, 1, 1, 1, 1, -129, -128, 127));
        tbl.push_back(mk(0, 1, 3, 3, 77, 1, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // backpressure on ch3 (out of range for the 3-channel bank)
        apply(mk(0, 1, 3, 0, 5, 1, 1, 5, 5, 0));
        for (int i = 0; i < 3; i++) apply(mk(0, 1, 3, 0, 1, 0, 1, 5, 5, 0));
        apply(mk(0, 1, 3, 0, 1, 1, 1, 6, 6, 0));
        apply(mk(0, 1, 3, 0, 1, 1, 1, 7, 7, 0));
        apply(mk(0, 0, 0, 0, 0, 1));

        // interleaved channels
        apply(mk(0, 1, 0, 3, 0, 1, 1, 0, 0, 0));
        apply(mk(0, 1, 1, 3, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            apply(mk(0, 1, i % 2, i % 2, 1, 1));
        apply(mk(0, 1, 0, 0, 0, 1, 1, 5, 5, 5));
        apply(mk(0, 1, 1, 0, 0, 1, 1, -5, -5, -5));

        // random stream, then reset mid-stream with an op on the reset edge
        for (int i = 0; i < 300; i++) apply(rnd());
        apply(mk(1, 1, 0, 2, 99, 1));
        apply(mk(0, 0, 0, 0, 0, 1));
        for (int c = 0; c < 4; c++) apply(mk(0, 1, c, 0, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 400; i++) apply(rnd());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
